// File: rtl/image_write.sv
// Captures a VSYNC/HSYNC-framed stream of 8-bit pixel pairs into a WIDTH x HEIGHT frame buffer,
// flags completion and protocol errors, and offers a 1-cycle-latency raster-order read port.
module image_write #(
   parameter int WIDTH  = 320,   // must be even
   parameter int HEIGHT = 240,
   parameter int AW     = 17     // 2**AW >= WIDTH*HEIGHT
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          VSYNC,
   input  logic          HSYNC,
   input  logic [7:0]    DATA_0,
   input  logic [7:0]    DATA_1,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic          frame_done,
   output logic          frame_err,
   output logic          ovf,
   output logic [9:0]    cur_row,
   output logic [10:0]   cur_col
);

   localparam int            NPIX      = WIDTH * HEIGHT;
   localparam int            IW        = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam logic [AW-1:0] LAST_PAIR = AW'(NPIX / 2 - 1);
   localparam logic [AW-1:0] NPIX_A    = AW'(NPIX);
   localparam logic [10:0]   COL_LAST  = 11'(WIDTH - 2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    row_q, row_d;
   logic [10:0]   col_q, col_d;
   logic [AW-1:0] pair_q, pair_d;
   logic          err_q, err_d;
   logic          ovf_q, ovf_d;
   logic          wr_en;

   logic [7:0]    mem [NPIX];
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] wr_addr1;

   assign wr_addr  = AW'(row_q) * AW'(WIDTH) + AW'(col_q);
   assign wr_addr1 = wr_addr + AW'(1);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         pair_q  <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         pair_q  <= pair_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   // VSYNC takes priority over HSYNC in every state; a VSYNC cycle never writes.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      pair_d  = pair_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (VSYNC) begin
               state_d = ST_RECV;
               row_d   = '0;
               col_d   = '0;
               pair_d  = '0;
            end else if (HSYNC) begin
               ovf_d = 1'b1;
            end
         end
         ST_RECV: begin
            if (VSYNC) begin
               row_d  = '0;
               col_d  = '0;
               pair_d = '0;
               if (pair_q != '0) err_d = 1'b1;
            end else if (HSYNC) begin
               wr_en  = 1'b1;
               pair_d = pair_q + AW'(1);
               if (pair_q == LAST_PAIR) begin
                  state_d = ST_DONE;
                  row_d   = '0;
                  col_d   = '0;
               end else if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + 10'd1;
               end else begin
                  col_d = col_q + 11'd2;
               end
            end
         end
         ST_DONE: begin
            if (VSYNC) begin
               state_d = ST_RECV;
               row_d   = '0;
               col_d   = '0;
               pair_d  = '0;
            end else if (HSYNC) begin
               ovf_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         mem[wr_addr[IW-1:0]]  <= DATA_0;
         mem[wr_addr1[IW-1:0]] <= DATA_1;
      end
   end

   // Same-edge read of a location being written returns the pre-write contents.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rd_valid <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_data <= (rd_addr < NPIX_A) ? mem[rd_addr[IW-1:0]] : 8'h00;
      end
   end

   assign frame_done = (state_q == ST_DONE);
   assign frame_err  = err_q;
   assign ovf        = ovf_q;
   assign cur_row    = row_q;
   assign cur_col    = col_q;

endmodule

// File: doc/image_write.md
Name: image_write

Overview:
- Receiving end of the pixel-pair stream produced by the image reader.
- Captures VSYNC/HSYNC-framed 8-bit pixel pairs into an internal WIDTH x HEIGHT frame buffer, tracking row and column.
- Flags frame completion and protocol errors.
- Exposes a registered read port so a testbench or downstream disparity stage can retrieve the stored frame in raster order.

Parameters:
- WIDTH, 320, pixels per line; must be even.
- HEIGHT, 240, lines per frame.
- AW, 17, buffer address width; requires 2^AW >= WIDTH*HEIGHT.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- VSYNC  in  1  frame-start indication; high for one or more cycles before the first data cycle.
- HSYNC  in  1  data-valid; DATA_0/DATA_1 are valid on every cycle HSYNC=1.
- DATA_0  in  8  even pixel (col).
- DATA_1  in  8  odd pixel (col+1).
- rd_en  in  1  read request.
- rd_addr  in  AW  raster pixel address (WIDTH*row+col).
- rd_data  out  8  read data.
- rd_valid  out  1  rd_data valid.
- frame_done  out  1  full frame captured; level signal.
- frame_err  out  1  sticky: frame aborted by VSYNC before completion.
- ovf  out  1  sticky: HSYNC data received while not in RECV.
- cur_row  out  10  current write row.
- cur_col  out  11  current write column (always even).

Behaviour:
- Reset (async, HRESETn=0):
  - State = ST_IDLE; row, col and pair counter = 0.
  - frame_done, frame_err, ovf, rd_valid = 0; rd_data = 0.
  - Buffer contents are not cleared.
- FSM states: ST_IDLE, ST_RECV, ST_DONE. All transitions occur on the HCLK rising edge.
- ST_IDLE:
  - VSYNC=1 -> ST_RECV; counters cleared.
  - HSYNC=1 with VSYNC=0 -> ovf<=1, data dropped.
- ST_RECV:
  - Each cycle with HSYNC=1 and VSYNC=0: buf[WIDTH*row+col] <= DATA_0 and buf[WIDTH*row+col+1] <= DATA_1 (both written the same cycle); pair counter +1.
  - Column update: if col == WIDTH-2 then col<=0 and row<=row+1, else col<=col+2.
  - HSYNC=0 cycles (line gaps) leave counters unchanged.
  - Write of pair number WIDTH*HEIGHT/2 -> ST_DONE.
    - frame_done=1 from the following cycle.
    - row and col wrap to 0.
  - VSYNC=1 (with or without HSYNC) before completion:
    - Counters cleared; data that cycle dropped.
    - frame_err<=1 only if pair counter != 0.
    - Stay in ST_RECV.
- ST_DONE:
  - frame_done=1 throughout.
  - HSYNC=1 with VSYNC=0 -> ovf<=1, data dropped, no buffer write.
  - VSYNC=1 -> ST_RECV; frame_done<=0 and counters cleared the same edge.
- Flag clearing: frame_err and ovf are cleared only by reset.
- Simultaneous VSYNC and HSYNC: VSYNC always wins; no write occurs.
- Read port:
  - rd_en=1 at edge N -> rd_data = buf[rd_addr] and rd_valid=1 after edge N (1-cycle latency).
  - rd_en=0 -> rd_valid=0 and rd_data holds its last value.
  - Reads are legal in any state.
  - Read and write to the same address in the same cycle returns the old data.
  - rd_addr >= WIDTH*HEIGHT returns 0.
- Reset mid-frame: all control returns to reset values immediately; the partial frame is discarded logically (buffer contents stale).
- Arithmetic:
  - Address = row*WIDTH + col computed in AW bits.
  - Pair counter width is AW bits.
  - No saturation needed: the counter never exceeds WIDTH*HEIGHT/2.

Test Plan (WIDTH=8, HEIGHT=4 unless noted):
- Nominal frame:
  - Stimulus: VSYNC 1 cycle, then 4 lines of 4 HSYNC cycles each separated by 3 idle cycles; DATA_0=2k, DATA_1=2k+1 for pair k.
  - Required: frame_done=1 the cycle after pair 15; reads of addr 0..31 return 0..31 with rd_valid one cycle after rd_en.
- Line gaps:
  - Stimulus: HSYNC deasserted randomly mid-line.
  - Required: cur_col holds during gaps; final buffer identical to the nominal case.
- Abort:
  - Stimulus: VSYNC after 5 pairs, then a full frame with DATA_0=0xA0+k.
  - Required: frame_err=1 sticky; frame_done after 16 new pairs; addr 0 reads 0xA0.
- Overflow:
  - Stimulus: 2 extra HSYNC pairs after frame_done.
  - Required: ovf=1; buffer unchanged (addr 0 still 0); frame_done stays 1.
- VSYNC+HSYNC same cycle:
  - Stimulus: VSYNC and HSYNC asserted together with DATA_0=0xFF.
  - Required: no write; cur_col=0 afterwards.
- Reset mid-frame:
  - Stimulus: HRESETn low for 1 cycle after 7 pairs.
  - Required: state IDLE, cur_row=0, cur_col=0, frame_done=0, frame_err=0; next VSYNC plus full frame completes normally.
